// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// State encoding and RV32 load/store width codes.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    ERR_RESP = 2'd2
  } state_t;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

endpackage

// File: rtl/dmem_align_check.sv
// Legality check of one memory command.
// Ports: funct3, addr_lo (addr[1:0]), we in; bad out (misaligned/illegal).
module dmem_align_check
  import dmem_arb_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  input  logic       we,
  output logic       bad
);

  always_comb begin
    bad = 1'b1;
    case (funct3)
      FUNCT3_B:  bad = 1'b0;
      FUNCT3_H:  bad = addr_lo[0];
      FUNCT3_W:  bad = |addr_lo;
      // unsigned widths exist only for loads
      FUNCT3_BU: bad = we;
      FUNCT3_HU: bad = we | addr_lo[0];
      default:   bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between CPU (r0) and DMA (r1).
// Ports: clk, rst; per requester req/we/addr/wdata/funct3 in, gnt/rvalid/rdata/err out;
// memory strobes, address, write data, funct3 out; mem_read_data in.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic [2:0]        r0_funct3,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic [2:0]        r1_funct3,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_t state, state_n;

  logic              any_req, sel, sel_bad, last;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [2:0]        sel_f3;

  logic              owner, cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [2:0]        cmd_f3;

  logic              resp_v, resp_own;
  logic [DATA_W-1:0] resp_data;
  logic              in_acc, in_err, rv0, rv1;

  assign any_req = r0_req | r1_req;

  // on a tie, grant whoever was not granted last
  always_comb begin
    sel = r1_req & ~r0_req;
    if (r0_req && r1_req) sel = ~last;
  end

  assign sel_we    = sel ? r1_we     : r0_we;
  assign sel_addr  = sel ? r1_addr   : r0_addr;
  assign sel_wdata = sel ? r1_wdata  : r0_wdata;
  assign sel_f3    = sel ? r1_funct3 : r0_funct3;

  dmem_align_check u_chk (
    .funct3  (sel_f3),
    .addr_lo (sel_addr[1:0]),
    .we      (sel_we),
    .bad     (sel_bad)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (any_req) state_n = sel_bad ? ERR_RESP : ACCESS;
      ACCESS:   state_n = IDLE;
      ERR_RESP: state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last      <= 1'b1;
      owner     <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_f3    <= '0;
      resp_v    <= 1'b0;
      resp_own  <= 1'b0;
      resp_data <= '0;
    end else begin
      resp_v <= 1'b0;
      if (state == IDLE && any_req) begin
        last      <= sel;
        owner     <= sel;
        cmd_we    <= sel_we;
        cmd_addr  <= sel_addr;
        cmd_wdata <= sel_wdata;
        cmd_f3    <= sel_f3;
      end
      // load data is taken at the end of ACCESS, returned next cycle
      if (state == ACCESS && !cmd_we) begin
        resp_v    <= 1'b1;
        resp_own  <= owner;
        resp_data <= mem_read_data;
      end
    end
  end

  assign mem_address    = cmd_addr;
  assign mem_write_data = cmd_wdata;
  assign mem_funct3     = cmd_f3;

  // everything visible is forced low while rst is high,
  // which also keeps an in-flight store from committing
  always_comb begin
    in_acc       = (state == ACCESS) & ~rst;
    in_err       = (state == ERR_RESP) & ~rst;
    rv0          = resp_v & ~resp_own & ~rst;
    rv1          = resp_v & resp_own & ~rst;
    mem_MemRead  = in_acc & ~cmd_we;
    mem_MemWrite = in_acc & cmd_we;
    r0_gnt       = (in_acc | in_err) & ~owner;
    r1_gnt       = (in_acc | in_err) & owner;
    r0_err       = in_err & ~owner;
    r1_err       = in_err & owner;
    r0_rvalid    = rv0 | r0_err;
    r1_rvalid    = rv1 | r1_err;
    r0_rdata     = rv0 ? resp_data : '0;
    r1_rdata     = rv1 ? resp_data : '0;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, requester/memory address width.
REQ-002 Parameter: DATA_W, 32, data width; only 32 is supported.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: rN_req  in  1  requester N (N=0 CPU, N=1 DMA) access request; level, held until granted.
REQ-006 Port: rN_we  in  1  1=store, 0=load.
REQ-007 Port: rN_addr  in  ADDR_W  byte address.
REQ-008 Port: rN_wdata  in  DATA_W  store data, right-aligned.
REQ-009 Port: rN_funct3  in  3  RV32 width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-010 Port: rN_gnt  out  1  one-cycle pulse, high in the cycle N's command is driven to memory.
REQ-011 Port: rN_rvalid  out  1  one-cycle pulse, response valid (loads and errored stores).
REQ-012 Port: rN_rdata  out  DATA_W  load result, valid with rN_rvalid.
REQ-013 Port: rN_err  out  1  misaligned or illegal funct3, valid with rN_rvalid.
REQ-014 Port: mem_MemRead, mem_MemWrite  out  1 each  memory strobes.
REQ-015 Port: mem_address, mem_write_data  out  ADDR_W/DATA_W  memory command.
REQ-016 Port: mem_funct3  out  3  forwarded width code.
REQ-017 Port: mem_read_data  in  DATA_W  combinational memory read result.

Function
REQ-018 FSM states IDLE, ACCESS, ERR_RESP; reset state IDLE.
REQ-019 IDLE, any valid req: winner's addr/we/wdata/funct3 registered at the edge, go to ACCESS.
REQ-020 Arbitration is round-robin: both requesting, grant the requester not granted last; single requester always wins.
REQ-021 Last-grant pointer resets to 1 so r0 wins the first tie.
REQ-022 ACCESS lasts exactly one cycle: strobes driven from registered command, winner's gnt=1, then return to IDLE.
REQ-023 Load: mem_read_data captured at the end of ACCESS; rN_rvalid=1 with rN_rdata in the following cycle (issue-to-data latency 2).
REQ-024 Store: no rvalid on success; write commits at the edge ending ACCESS.
REQ-025 Requester deasserts req or presents a new command at the edge after its gnt; sustained throughput is one access per 2 cycles.
REQ-026 Misaligned access (h/hu with addr[0]=1; w with addr[1:0]!=0) or funct3 in {011,110,111} (or 100/101 with we=1) goes to ERR_RESP: no strobe asserted, gnt pulse and rvalid+err=1, rdata=0 in that cycle, then IDLE.
REQ-027 Error requests participate in round-robin and update the pointer like valid ones.
REQ-028 mem_MemRead and mem_MemWrite never both 1; both 0 outside ACCESS; mem_address/mem_write_data hold last command when idle.
REQ-029 Requests arriving while not in IDLE are ignored until IDLE; no queueing.

Reset
REQ-030 While rst=1: gnt, rvalid, err, strobes = 0; rdata = 0; state IDLE; pointer = 1.
REQ-031 mem_MemWrite gated by ~rst so a store in ACCESS during reset does not commit.
REQ-032 Pending load responses are dropped by reset; no rvalid after reset release without a new grant.

Structure
REQ-033 Shared package dmem_arb_pkg holds state enum and funct3 width constants (FUNCT3_B/H/W/BU/HU).
REQ-034 Sub-module dmem_align_check: combinational funct3/addr/we legality check, instanced once on the selected request.

Verification
REQ-035 r0 lw 0x10 after sw 0x10=0xDEADBEEF -> r0_gnt at ACCESS, r0_rvalid 2 cycles after issue, rdata=0xDEADBEEF.
REQ-036 r0 and r1 request lw continuously from reset -> grants alternate r0,r1,r0,r1, one every 2 cycles.
REQ-037 r1 lh addr 0x21 -> r1_rvalid=1, r1_err=1, rdata=0, mem strobes stay 0.
REQ-038 r0 sw 0x40=0x12345678 with rst asserted in ACCESS -> later lw 0x40 returns prior contents, not 0x12345678.
REQ-039 Only r1 requesting sb 0x8=0xAB repeatedly -> r1 granted every 2 cycles, r0 outputs stay 0.
